csa_sub_pipe: RTL and testbench

Two-stage pipelined 32-bit carry-select subtractor with valid/ready handshake. It computes `a - b - bin` and returns the difference with a borrow-out. It is the subtract-direction companion to the combinational carry-select adder in the adders library. The carry-select split is placed across a register boundary so that each stage's critical path is one 16-bit half.

---
 rtl/csa_pkg.sv | 30 +++
 rtl/csa_sub_pipe_csel_group.sv | 40 ++++
 rtl/csa_sub_pipe.sv | 161 ++++++++++++++++
 tb/tb_csa_sub_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_pkg
//  Brief    : Shared constants and stage-1 payload type for csa_sub_pipe.
//             With CSA_SUB_OVF_EN defined, the payload also carries the
//             operand sign bits that the signed-overflow flag needs.
//  Revision : 1.0  initial release
// ============================================================================
package csa_pkg;

  localparam int CSA_WIDTH = 32;
  localparam int CSA_GROUP = 4;
  localparam int CSA_HALF  = CSA_WIDTH / 2;

  // Everything stage 2 needs in order to finish the subtraction.
  typedef struct packed {
    logic [CSA_HALF-1:0] diff_lo;  // finished low half
    logic                c_lo;     // carry out of the low half
    logic [CSA_HALF-1:0] hi0;      // upper half, assuming carry-in 0
    logic [CSA_HALF-1:0] hi1;      // upper half, assuming carry-in 1
    logic                c0;       // upper carry-out for carry-in 0
    logic                c1;       // upper carry-out for carry-in 1
`ifdef CSA_SUB_OVF_EN
    logic                a_msb;    // minuend sign
    logic                b_msb;    // subtrahend sign
`endif
  } s1_payload_t;

endpackage : csa_pkg
`default_nettype wire

// File: rtl/csa_sub_pipe_csel_group.sv
`default_nettype none
// ============================================================================
//  Module   : csel_group
//  Brief    : GROUP-bit dual-rail ripple block. Produces the sum and carry
//             for both possible carry-in values so the caller only has to
//             select once the real carry is known.
//  Revision : 1.0  initial release
// ============================================================================
module csel_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  output logic [GROUP-1:0] o_s0,
  output logic [GROUP-1:0] o_s1,
  output logic             o_c0,
  output logic             o_c1
);

  logic w_k0;
  logic w_k1;

  // Two parallel bit-serial ripples, one per assumed carry-in.
  always_comb begin
    w_k0 = 1'b0;
    w_k1 = 1'b1;
    o_s0 = '0;
    o_s1 = '0;
    for (int i = 0; i < GROUP; i++) begin
      o_s0[i] = i_a[i] ^ i_b[i] ^ w_k0;
      o_s1[i] = i_a[i] ^ i_b[i] ^ w_k1;
      w_k0    = (i_a[i] & i_b[i]) | (w_k0 & (i_a[i] ^ i_b[i]));
      w_k1    = (i_a[i] & i_b[i]) | (w_k1 & (i_a[i] ^ i_b[i]));
    end
    o_c0 = w_k0;
    o_c1 = w_k1;
  end

endmodule : csel_group
`default_nettype wire

// File: rtl/csa_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : csa_sub_pipe
//  Brief    : Two-stage pipelined carry-select subtractor, diff = a - b - bin,
//             with borrow-out and valid/ready handshake. Stage 1 resolves the
//             low half and both upper-half candidates; stage 2 selects.
//             Optional macro CSA_SUB_OVF_EN adds the signed-overflow port ovf.
//  Revision : 1.0  initial release
// ============================================================================
module csa_sub_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,  // must equal CSA_WIDTH (payload is sized by it)
  parameter int GROUP = CSA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / GROUP;

  // a - b - bin is computed as a + ~b + ~bin; borrow is the inverted carry.
  logic [WIDTH-1:0] w_bn;
  logic [HALF-1:0]  w_lo_s, w_h0_s, w_h1_s;
  logic [NGRP:0]    w_lo_c, w_h0_c, w_h1_c;

  assign w_bn      = ~b;
  assign w_lo_c[0] = ~bin;
  assign w_h0_c[0] = 1'b0;
  assign w_h1_c[0] = 1'b1;

  // Low half: one real carry rippled group to group through the selects.
  for (genvar g = 0; g < NGRP; g++) begin : g_lo
    logic [GROUP-1:0] w_s0, w_s1;
    logic             w_c0, w_c1;
    csel_group #(.GROUP(GROUP)) u_grp (
      .i_a  (a[g*GROUP +: GROUP]),
      .i_b  (w_bn[g*GROUP +: GROUP]),
      .o_s0 (w_s0),
      .o_s1 (w_s1),
      .o_c0 (w_c0),
      .o_c1 (w_c1)
    );
    assign w_lo_s[g*GROUP +: GROUP] = w_lo_c[g] ? w_s1 : w_s0;
    assign w_lo_c[g+1]              = w_lo_c[g] ? w_c1 : w_c0;
  end

  // Upper half: the same group outputs feed two chains, one per half carry-in.
  for (genvar g = 0; g < NGRP; g++) begin : g_hi
    logic [GROUP-1:0] w_s0, w_s1;
    logic             w_c0, w_c1;
    csel_group #(.GROUP(GROUP)) u_grp (
      .i_a  (a[HALF + g*GROUP +: GROUP]),
      .i_b  (w_bn[HALF + g*GROUP +: GROUP]),
      .o_s0 (w_s0),
      .o_s1 (w_s1),
      .o_c0 (w_c0),
      .o_c1 (w_c1)
    );
    assign w_h0_s[g*GROUP +: GROUP] = w_h0_c[g] ? w_s1 : w_s0;
    assign w_h0_c[g+1]              = w_h0_c[g] ? w_c1 : w_c0;
    assign w_h1_s[g*GROUP +: GROUP] = w_h1_c[g] ? w_s1 : w_s0;
    assign w_h1_c[g+1]              = w_h1_c[g] ? w_c1 : w_c0;
  end

  s1_payload_t w_s1_next;
  s1_payload_t r_s1;
  logic        r_s1_valid;
  logic        r_s2_valid;
  logic [WIDTH-1:0] r_diff;
  logic        r_bout;
  logic        w_s2_adv, w_s1_adv, w_accept;
  logic [WIDTH-1:0] w_diff_nx;
  logic        w_carry_nx;

  // Pack the stage-1 results.
  always_comb begin
    w_s1_next         = '0;
    w_s1_next.diff_lo = w_lo_s;
    w_s1_next.c_lo    = w_lo_c[NGRP];
    w_s1_next.hi0     = w_h0_s;
    w_s1_next.hi1     = w_h1_s;
    w_s1_next.c0      = w_h0_c[NGRP];
    w_s1_next.c1      = w_h1_c[NGRP];
`ifdef CSA_SUB_OVF_EN
    w_s1_next.a_msb   = a[WIDTH-1];
    w_s1_next.b_msb   = b[WIDTH-1];
`endif
  end

  // A stage advances when its successor can take data or it holds a bubble.
  assign w_s2_adv = out_ready | ~r_s2_valid;
  assign w_s1_adv = w_s2_adv | ~r_s1_valid;
  assign in_ready = w_s1_adv;
  assign w_accept = in_valid & w_s1_adv;

  // Stage 2 is a single mux level on the registered candidates.
  assign w_diff_nx  = {r_s1.c_lo ? r_s1.hi1 : r_s1.hi0, r_s1.diff_lo};
  assign w_carry_nx = r_s1.c_lo ? r_s1.c1 : r_s1.c0;

  // Stage-1 valid and payload; a bubble stage keeps its old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (w_s1_adv) r_s1_valid <= w_accept;
      if (w_accept) r_s1       <= w_s1_next;
    end
  end

  // Stage-2 valid and result registers; results only change on a real load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff <= w_diff_nx;
        r_bout <= ~w_carry_nx;
      end
    end
  end

`ifdef CSA_SUB_OVF_EN
  logic r_ovf;

  // Overflow only when operand signs differ and the result sign leaves a's.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_ovf <= (r_s1.a_msb != r_s1.b_msb) && (w_diff_nx[WIDTH-1] != r_s1.a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;

endmodule : csa_sub_pipe
`default_nettype wire

// File: tb/tb_csa_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_sub_pipe
//  Brief    : Scoreboard bench for csa_sub_pipe. Expected results come from
//             plain wide-integer arithmetic on the operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa_sub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bout;
`ifdef CSA_SUB_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  csa_sub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef CSA_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rr_mode = 1'b0;
  logic ready_val = 1'b0;

  // Reference: exact integer subtraction, unsigned and signed.
  function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic bi);
    exp_t   e;
    longint ur, sr;
    ur   = longint'(x) - longint'(y) - longint'(bi);
    sr   = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
    e.d  = 32'(ur);
    e.bo = (ur < 0);
    e.ov = (sr > longint'(2147483647)) || (sr < (-longint'(2147483647) - 1));
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Consumer side: out_ready either random or held at a chosen level.
  always begin
    @(posedge clk);
    #2;
    out_ready = rr_mode ? 1'($urandom_range(0, 1)) : ready_val;
  end

  logic        held_v = 1'b0;
  logic [31:0] held_d;
  logic        held_b;
`ifdef CSA_SUB_OVF_EN
  logic        held_o;
`endif

  // Monitor: pop and compare on each handshake, check stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_diff_hold", diff, held_d);
        chk("stall_bout_hold", bout, held_b);
`ifdef CSA_SUB_OVF_EN
        chk("stall_ovf_hold", ovf, held_o);
`endif
      end
      held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got diff %0h expected no output", diff);
        end else begin
          e = sb_q.pop_front();
          chk("diff", diff, e.d);
          chk("bout", bout, e.bo);
`ifdef CSA_SUB_OVF_EN
          chk("ovf", ovf, e.ov);
`endif
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held_d = diff;
        held_b = bout;
`ifdef CSA_SUB_OVF_EN
        held_o = ovf;
`endif
      end
    end
  end

  // Present one beat until accepted; returns at posedge+1 after acceptance.
  task automatic send(logic [31:0] x, logic [31:0] y, logic bi);
    int t;
    t        = 0;
    a        = x;
    b        = y;
    bin      = bi;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else begin
      sb_q.push_back(model(x, y, bi));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(nm, sb_q.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [4];
    sp[0] = 32'h0000_0000;
    sp[1] = 32'hFFFF_FFFF;
    sp[2] = 32'h8000_0000;
    sp[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  initial begin
    int acc;
    int i;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_val = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef CSA_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(posedge clk);
    #1;

    // Latency: valid rises exactly two edges after the accepting cycle
    a = 32'd5; b = 32'd3; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    sb_q.push_back(model(32'd5, 32'd3, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_edge2_valid", out_valid, 1);
    drain("lat_drain");

    // Directed corner operands
    send(32'h0000_0000, 32'h0000_0001, 1'b0);
    send(32'h0001_0000, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain("dir_drain");

    // Backpressure: consumer stalls for 5 cycles while 4 beats are offered
    ready_val = 1'b0;
    @(posedge clk);
    #1;
    acc = 0;
    i   = 0;
    for (int c = 0; c < 5; c++) begin
      if (i < 4) begin
        a = 32'(i + 10); b = 32'(i); bin = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_q.push_back(model(32'(i + 10), 32'(i), 1'b0));
        i++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready_low", in_ready, 0);
    ready_val = 1'b1;
    while (i < 4) begin
      send(32'(i + 10), 32'(i), 1'b0);
      i++;
    end
    drain("bp_drain");

    // Reset mid-stream discards in-flight beats
    ready_val = 1'b0;
    @(posedge clk);
    #1;
    send(32'd100, 32'd1, 1'b0);
    send(32'd200, 32'd2, 1'b0);
    rst      = 1'b1;
    a        = 32'd99;
    b        = 32'd1;
    in_valid = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    ready_val = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_no_output", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'd7, 32'd2, 1'b0);
    drain("mid_rst_drain");

    // Randomized traffic with random consumer backpressure
    rr_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)));
    end
    rr_mode   = 1'b0;
    ready_val = 1'b1;
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog against a hung handshake.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_csa_sub_pipe
`default_nettype wire
